// File: rtl/apb_master_lsu_pkg.sv
// ------------------------------------------------------------------------
// lsu_pkg : shared state, funct3 and address-map constants for the APB LSU
// rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_FAULT  = 2'd3
   } lsu_state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   localparam int          NUM_MAP  = 4;
   localparam logic [31:0] SLV_MASK = 32'hFFFF_F000;
   localparam logic [NUM_MAP-1:0][31:0] SLV_BASE = {
      32'h1000_3000,   // UART
      32'h1000_2000,   // GPI
      32'h1000_1000,   // GPO
      32'h1000_0000    // RAM
   };

   // Size/alignment legality of an access; funct3[1:0] encodes the size.
   function automatic logic access_legal(input logic [2:0] f3, input logic [1:0] off);
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111)
         return 1'b0;
      case (f3[1:0])
         2'b01:   return ~off[0];
         2'b10:   return (off == 2'b00);
         default: return 1'b1;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/apb_master_lsu_if.sv
// ------------------------------------------------------------------------
// apb_master_lsu_if : CPU load/store port plus APB master bus, rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

interface apb_master_lsu_if #(
   parameter int ADDR_W = 32,
   parameter int NSLV   = 4
);
   logic                     req;
   logic                     we;
   logic [2:0]               funct3;
   logic [ADDR_W-1:0]        addr;
   logic [31:0]              wdata;
   logic [31:0]              rdata;
   logic                     ready;
   logic                     err;

   logic [ADDR_W-1:0]        paddr;
   logic [31:0]              pwdata;
   logic [3:0]               pstrb;
   logic                     pwrite;
   logic                     penable;
   logic [NSLV-1:0]          psel;
   logic [NSLV-1:0][31:0]    prdata;
   logic [NSLV-1:0]          pready;

   modport master (
      input  req, we, funct3, addr, wdata, prdata, pready,
      output rdata, ready, err, paddr, pwdata, pstrb, pwrite, penable, psel
   );

   modport slave (
      output req, we, funct3, addr, wdata, prdata, pready,
      input  rdata, ready, err, paddr, pwdata, pstrb, pwrite, penable, psel
   );

endinterface

`default_nettype wire

// File: rtl/apb_master_lsu_lane_align.sv
// ------------------------------------------------------------------------
// lsu_lane_align : byte-lane strobes/replication for stores, load extract
// rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module lsu_lane_align (
   input  logic        we,
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] prdata,
   output logic [3:0]  pstrb,
   output logic [31:0] pwdata,
   output logic [31:0] rdata
);

   logic [15:0] shifted;

   always_comb begin
      shifted = 16'(prdata >> {offset, 3'b000});
      pstrb   = 4'b0000;
      pwdata  = wdata;
      rdata   = prdata;
      case (funct3[1:0])
         2'b00: begin
            pstrb  = 4'b0001 << offset;
            pwdata = {4{wdata[7:0]}};
            rdata  = funct3[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
         end
         2'b01: begin
            pstrb  = 4'b0011 << offset;
            pwdata = {2{wdata[15:0]}};
            rdata  = funct3[2] ? {16'd0, shifted} : {{16{shifted[15]}}, shifted};
         end
         default: begin
            pstrb  = 4'b1111;
            pwdata = wdata;
            rdata  = prdata;
         end
      endcase
      if (!we)
         pstrb = 4'b0000;
   end

endmodule

`default_nettype wire

// File: rtl/apb_master_lsu.sv
// ------------------------------------------------------------------------
// apb_master_lsu : RV32I load/store unit driving an NSLV-slave APB bus
// rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module apb_master_lsu
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int NSLV   = 4
) (
   input  logic               clk,
   input  logic               reset,
   apb_master_lsu_if.master   bus
);

   lsu_state_t          state;
   lsu_state_t          state_nxt;

   logic                cap_we;
   logic [2:0]          cap_funct3;
   logic [ADDR_W-1:0]   cap_addr;
   logic [31:0]         cap_wdata;
   logic [NSLV-1:0]     cap_sel;

   logic [31:0]         addr32;
   logic [NSLV-1:0]     hit;
   logic                mapped;
   logic                legal;
   logic                active;
   logic                done;
   logic                sel_ready;
   logic [31:0]         sel_prdata;
   logic [31:0]         load_data;
   logic [31:0]         lane_wdata;
   logic [3:0]          lane_strb;

   assign addr32 = 32'(bus.addr);

   // Slaves beyond the fixed map never decode.
   for (genvar s = 0; s < NSLV; s++) begin : g_decode
      if (s < NUM_MAP) begin : g_mapped
         assign hit[s] = ((addr32 & SLV_MASK) == SLV_BASE[s]);
      end else begin : g_unmapped
         assign hit[s] = 1'b0;
      end
   end

   assign mapped = |hit;
   assign legal  = access_legal(bus.funct3, bus.addr[1:0]);

   always_comb begin
      sel_prdata = 32'd0;
      sel_ready  = 1'b0;
      for (int s = 0; s < NSLV; s++) begin
         if (cap_sel[s]) begin
            sel_prdata = sel_prdata | bus.prdata[s];
            sel_ready  = sel_ready  | bus.pready[s];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         cap_we     <= 1'b0;
         cap_funct3 <= 3'd0;
         cap_addr   <= '0;
         cap_wdata  <= 32'd0;
         cap_sel    <= '0;
      end else begin
         state <= state_nxt;
         if (state == ST_IDLE && bus.req) begin
            cap_we     <= bus.we;
            cap_funct3 <= bus.funct3;
            cap_addr   <= bus.addr;
            cap_wdata  <= bus.wdata;
            cap_sel    <= hit;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (bus.req) state_nxt = (mapped && legal) ? ST_SETUP : ST_FAULT;
         ST_SETUP:  state_nxt = ST_ACCESS;
         ST_ACCESS: if (sel_ready) state_nxt = ST_IDLE;
         ST_FAULT:  state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   lsu_lane_align u_lane (
      .we     (cap_we),
      .funct3 (cap_funct3),
      .offset (cap_addr[1:0]),
      .wdata  (cap_wdata),
      .prdata (sel_prdata),
      .pstrb  (lane_strb),
      .pwdata (lane_wdata),
      .rdata  (load_data)
   );

   assign active = (state == ST_SETUP) || (state == ST_ACCESS);
   assign done   = (state == ST_ACCESS) && sel_ready;

   // Bus outputs are idle-zero so a reset or fault never leaks a stale select.
   assign bus.psel    = active ? cap_sel : '0;
   assign bus.penable = (state == ST_ACCESS);
   assign bus.pwrite  = active & cap_we;
   assign bus.paddr   = active ? {cap_addr[ADDR_W-1:2], 2'b00} : '0;
   assign bus.pstrb   = active ? lane_strb : 4'b0000;
   assign bus.pwdata  = (active && cap_we) ? lane_wdata : 32'd0;
   assign bus.ready   = done || (state == ST_FAULT);
   assign bus.err     = (state == ST_FAULT);
   assign bus.rdata   = (done && !cap_we) ? load_data : 32'd0;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_lsu.sv
// ------------------------------------------------------------------------
// tb_apb_master_lsu : vector table, random transfers vs reference model
// rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module tb_apb_master_lsu;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   apb_master_lsu_if #(.ADDR_W(32), .NSLV(4)) bus ();

   apb_master_lsu #(.ADDR_W(32), .NSLV(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rd;
      int          waits;
      logic        xf;
      logic [3:0]  xpsel;
      logic [3:0]  xstrb;
      logic [31:0] xpwd;
      logic [31:0] xrd;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, "_psel"},    32'(bus.psel),    32'd0);
      check({tag, "_penable"}, 32'(bus.penable), 32'd0);
      check({tag, "_pwrite"},  32'(bus.pwrite),  32'd0);
      check({tag, "_pstrb"},   32'(bus.pstrb),   32'd0);
      check({tag, "_paddr"},   bus.paddr,        32'd0);
      check({tag, "_pwdata"},  bus.pwdata,       32'd0);
      check({tag, "_ready"},   32'(bus.ready),   32'd0);
      check({tag, "_err"},     32'(bus.err),     32'd0);
      check({tag, "_rdata"},   bus.rdata,        32'd0);
   endtask

   task automatic scramble();
      bus.we     = 1'($urandom);
      bus.funct3 = 3'($urandom);
      bus.addr   = $urandom;
      bus.wdata  = $urandom;
   endtask

   task automatic rand_slaves();
      for (int k = 0; k < 4; k++) bus.prdata[k] = $urandom;
      bus.pready = 4'($urandom);
   endtask

   // Reference: byte-oriented view of the access, independent of any lane logic.
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rd,
                                 output logic xf, output logic [3:0] xpsel, output logic [3:0] xstrb,
                                 output logic [31:0] xpwd, output logic [31:0] xrd);
      int n, off, slv;
      off = int'(addr % 32'd4);
      case (f3[1:0])
         2'b00:   n = 1;
         2'b01:   n = 2;
         2'b10:   n = 4;
         default: n = 0;
      endcase
      slv = (addr >= 32'h1000_0000 && addr <= 32'h1000_3FFF) ?
            int'((addr - 32'h1000_0000) / 32'd4096) : -1;
      xf = (slv < 0) || (n == 0) || (f3 == 3'b110);
      if (!xf && (off % n) != 0) xf = 1'b1;
      xpsel = 4'd0; xstrb = 4'd0; xpwd = 32'd0; xrd = 32'd0;
      if (!xf) begin
         xpsel[slv] = 1'b1;
         if (we) begin
            for (int i = 0; i < 4; i++) xpwd[8*i +: 8] = wdata[8*(i % n) +: 8];
            for (int j = 0; j < n; j++) xstrb[off + j] = 1'b1;
         end else begin
            for (int j = 0; j < n; j++) xrd[8*j +: 8] = rd[8*(off + j) +: 8];
            if (!f3[2] && n < 4 && xrd[8*n - 1])
               for (int k = 8*n; k < 32; k++) xrd[k] = 1'b1;
         end
      end
   endfunction

   // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle.
   task automatic run_xfer(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rd, input int waits,
                           input logic xf, input logic [3:0] xpsel, input logic [3:0] xstrb,
                           input logic [31:0] xpwd, input logic [31:0] xrd);
      int slv = 0;
      logic [31:0] xpaddr;
      xpaddr = addr & 32'hFFFF_FFFC;
      for (int k = 0; k < 4; k++) if (xpsel[k]) slv = k;
      bus.req = 1'b1; bus.we = we; bus.funct3 = f3; bus.addr = addr; bus.wdata = wdata;
      rand_slaves();
      @(negedge clk);
      check("capture_ready", 32'(bus.ready), 32'd0);
      check("capture_psel",  32'(bus.psel),  32'd0);
      @(posedge clk); #1;
      scramble(); rand_slaves();
      if (xf) begin
         @(negedge clk);
         check("fault_ready",   32'(bus.ready),   32'd1);
         check("fault_err",     32'(bus.err),     32'd1);
         check("fault_rdata",   bus.rdata,        32'd0);
         check("fault_psel",    32'(bus.psel),    32'd0);
         check("fault_penable", 32'(bus.penable), 32'd0);
         @(posedge clk); #1;
         bus.req = 1'b0;
      end else begin
         @(negedge clk);
         check("setup_psel",    32'(bus.psel),    32'(xpsel));
         check("setup_penable", 32'(bus.penable), 32'd0);
         check("setup_paddr",   bus.paddr,        xpaddr);
         check("setup_pwrite",  32'(bus.pwrite),  32'(we));
         check("setup_pstrb",   32'(bus.pstrb),   32'(xstrb));
         check("setup_pwdata",  bus.pwdata,       xpwd);
         check("setup_ready",   32'(bus.ready),   32'd0);
         check("setup_rdata",   bus.rdata,        32'd0);
         @(posedge clk); #1;
         for (int w = 0; w <= waits; w++) begin
            scramble(); rand_slaves();
            bus.pready[slv] = (w == waits);
            bus.prdata[slv] = rd;
            @(negedge clk);
            check("access_psel",    32'(bus.psel),    32'(xpsel));
            check("access_penable", 32'(bus.penable), 32'd1);
            check("access_paddr",   bus.paddr,        xpaddr);
            check("access_pwrite",  32'(bus.pwrite),  32'(we));
            check("access_pstrb",   32'(bus.pstrb),   32'(xstrb));
            check("access_pwdata",  bus.pwdata,       xpwd);
            check("access_ready",   32'(bus.ready),   32'(w == waits));
            check("access_err",     32'(bus.err),     32'd0);
            check("access_rdata",   bus.rdata,        (w == waits) ? xrd : 32'd0);
            @(posedge clk); #1;
         end
         bus.req = 1'b0;
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog expired");
   end

   logic        r_we, r_xf;
   logic [2:0]  r_f3;
   logic [31:0] r_addr, r_wd, r_rd, r_xpwd, r_xrd;
   logic [3:0]  r_xpsel, r_xstrb;
   logic [1:0]  r_off;
   int          r_region, r_waits, r_pick;

   initial begin
      //            we    f3      addr          wdata          rd            w  xf    psel     strb     pwdata         rdata
      vecs.push_back('{1'b1, 3'b010, 32'h1000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 0, 1'b0, 4'b0001, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0000});
      vecs.push_back('{1'b0, 3'b000, 32'h1000_0007, 32'h0,         32'h80FF_FFFF, 0, 1'b0, 4'b0001, 4'b0000, 32'h0,         32'hFFFF_FF80});
      vecs.push_back('{1'b0, 3'b100, 32'h1000_0007, 32'h0,         32'h80FF_FFFF, 0, 1'b0, 4'b0001, 4'b0000, 32'h0,         32'h0000_0080});
      vecs.push_back('{1'b1, 3'b001, 32'h1000_1002, 32'h0000_1234, 32'h0,         0, 1'b0, 4'b0010, 4'b1100, 32'h1234_1234, 32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h1000_3000, 32'h0,         32'hCAFE_F00D, 3, 1'b0, 4'b1000, 4'b0000, 32'h0,         32'hCAFE_F00D});
      vecs.push_back('{1'b0, 3'b010, 32'h1000_0002, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 4'b0000, 32'h0,         32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h2000_0000, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 4'b0000, 32'h0,         32'h0});
      vecs.push_back('{1'b0, 3'b101, 32'h1000_2004, 32'h0,         32'h1234_8765, 1, 1'b0, 4'b0100, 4'b0000, 32'h0,         32'h0000_8765});
      vecs.push_back('{1'b0, 3'b001, 32'h1000_2006, 32'h0,         32'h8001_7FFF, 0, 1'b0, 4'b0100, 4'b0000, 32'h0,         32'hFFFF_8001});
      vecs.push_back('{1'b1, 3'b000, 32'h1000_1001, 32'h1234_56A5, 32'h0,         2, 1'b0, 4'b0010, 4'b0010, 32'hA5A5_A5A5, 32'h0});
      vecs.push_back('{1'b0, 3'b011, 32'h1000_0000, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 4'b0000, 32'h0,         32'h0});
      vecs.push_back('{1'b0, 3'b001, 32'h1000_0001, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 4'b0000, 32'h0,         32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h1000_3FFC, 32'h0,         32'h0102_0304, 0, 1'b0, 4'b1000, 4'b0000, 32'h0,         32'h0102_0304});
      vecs.push_back('{1'b0, 3'b010, 32'h1000_4000, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 4'b0000, 32'h0,         32'h0});
      vecs.push_back('{1'b0, 3'b010, 32'h0FFF_FFFC, 32'h0,         32'h0,         0, 1'b1, 4'b0000, 4'b0000, 32'h0,         32'h0});
      vecs.push_back('{1'b1, 3'b110, 32'h1000_0000, 32'h1,         32'h0,         0, 1'b1, 4'b0000, 4'b0000, 32'h0,         32'h0});
      vecs.push_back('{1'b1, 3'b001, 32'h1000_0003, 32'h1,         32'h0,         0, 1'b1, 4'b0000, 4'b0000, 32'h0,         32'h0});
      vecs.push_back('{1'b0, 3'b000, 32'h1000_0001, 32'h0,         32'h0000_7F00, 0, 1'b0, 4'b0001, 4'b0000, 32'h0,         32'h0000_007F});

      bus.req = 1'b0; bus.we = 1'b0; bus.funct3 = 3'd0; bus.addr = 32'd0; bus.wdata = 32'd0;
      bus.pready = 4'd0;
      for (int k = 0; k < 4; k++) bus.prdata[k] = 32'd0;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_quiet("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_quiet("idle");
      @(posedge clk); #1;

      foreach (vecs[i])
         run_xfer(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].rd, vecs[i].waits,
                  vecs[i].xf, vecs[i].xpsel, vecs[i].xstrb, vecs[i].xpwd, vecs[i].xrd);

      for (int it = 0; it < 60; it++) begin
         r_we = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) begin
            r_pick = int'($urandom_range(0, 2));
            r_f3 = (r_pick == 0) ? 3'b011 : (r_pick == 1) ? 3'b110 : 3'b111;
         end else if (r_we) begin
            r_f3 = 3'($urandom_range(0, 2));
         end else begin
            r_pick = int'($urandom_range(0, 4));
            r_f3 = (r_pick < 3) ? 3'(r_pick) : 3'(r_pick + 1);
         end
         r_off = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 3) != 0) begin
            if (r_f3[1:0] == 2'b01) r_off = r_off & 2'b10;
            if (r_f3[1:0] == 2'b10) r_off = 2'b00;
         end
         r_region = int'($urandom_range(0, 8));
         if (r_region == 4)
            r_addr = $urandom;
         else
            r_addr = 32'h1000_0000 + 32'((r_region % 4) * 4096)
                   + {20'd0, 10'($urandom_range(0, 1023)), r_off};
         r_wd    = $urandom;
         r_rd    = $urandom;
         r_waits = int'($urandom_range(0, 3));
         model(r_we, r_f3, r_addr, r_wd, r_rd, r_xf, r_xpsel, r_xstrb, r_xpwd, r_xrd);
         run_xfer(r_we, r_f3, r_addr, r_wd, r_rd, r_waits, r_xf, r_xpsel, r_xstrb, r_xpwd, r_xrd);
      end

      // Held request: one idle gap cycle between consecutive transfers.
      bus.req = 1'b1; bus.we = 1'b1; bus.funct3 = 3'b010;
      bus.addr = 32'h1000_0008; bus.wdata = 32'h1122_3344; bus.pready = 4'hF;
      @(negedge clk); check("b2b_c1_ready", 32'(bus.ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check("b2b_c2_psel", 32'(bus.psel), 32'd1);
      check("b2b_c2_penable", 32'(bus.penable), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check("b2b_c3_ready", 32'(bus.ready), 32'd1);
      @(posedge clk); #1;
      @(negedge clk); check("b2b_gap_ready", 32'(bus.ready), 32'd0);
      check("b2b_gap_psel", 32'(bus.psel), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check("b2b_setup_psel", 32'(bus.psel), 32'd1);
      check("b2b_setup_penable", 32'(bus.penable), 32'd0);
      @(posedge clk); #1;
      @(negedge clk); check("b2b_second_ready", 32'(bus.ready), 32'd1);
      @(posedge clk); #1;
      bus.req = 1'b0;

      // Asynchronous reset while waiting in ACCESS.
      bus.req = 1'b1; bus.we = 1'b0; bus.funct3 = 3'b010;
      bus.addr = 32'h1000_3000; bus.pready = 4'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      check("pre_reset_penable", 32'(bus.penable), 32'd1);
      check("pre_reset_psel",    32'(bus.psel),    32'd8);
      #1 reset = 1'b1;
      #1 check_quiet("reset_in_access");
      @(posedge clk); #1;
      bus.pready = 4'hF;
      @(negedge clk);
      check_quiet("reset_held");
      @(posedge clk); #1;
      reset = 1'b0;
      bus.req = 1'b0;
      @(negedge clk);
      check_quiet("after_reset");
      @(posedge clk); #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/apb_master_lsu.md
APB_MASTER_LSU -- requirements
Module: apb_master_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning bus address width.
REQ-002 SHALL have parameter NSLV, default 4, meaning number of APB slaves.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req  input  1  CPU load/store request, held until ready.
REQ-006 SHALL have port we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port funct3  input  3  access size and sign (RV32I load/store encoding).
REQ-008 SHALL have port addr  input  32  byte address from ALU result.
REQ-009 SHALL have port wdata  input  32  store data (rs2).
REQ-010 SHALL have port rdata  output  32  aligned, extended load data.
REQ-011 SHALL have port ready  output  1  transfer complete; CPU stall = req & ~ready.
REQ-012 SHALL have port err  output  1  access fault, valid with ready.
REQ-013 SHALL have ports paddr output 32, pwdata output 32, pstrb output 4, pwrite output 1, penable output 1, psel output NSLV (one-hot).
REQ-014 SHALL have ports prdata input NSLV x 32, pready input NSLV, per slave.

Function
REQ-015 SHALL implement FSM IDLE, SETUP, ACCESS, FAULT.
REQ-016 IDLE with req=1: capture addr/we/funct3/wdata; mapped and aligned -> SETUP, otherwise -> FAULT; req=0 -> stay IDLE.
REQ-017 SETUP: psel[slave]=1, penable=0, unconditionally -> ACCESS next cycle.
REQ-018 ACCESS: psel[slave]=1, penable=1; stay while selected pready=0; on pready=1 drive ready=1 combinationally same cycle, -> IDLE.
REQ-019 FAULT: ready=1, err=1, rdata=0 for exactly one cycle, no psel, -> IDLE.
REQ-020 Minimum latency: ready asserted in the 3rd cycle counting the req-capture cycle as 1; wait states add one cycle each.
REQ-021 Address map: slave0 RAM 0x1000_0000-0x1000_0FFF, slave1 GPO 0x1000_1000-0x1000_1FFF, slave2 GPI 0x1000_2000-0x1000_2FFF, slave3 UART 0x1000_3000-0x1000_3FFF; any other address is unmapped.
REQ-022 Misaligned: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL go to FAULT; funct3 values 011, 110, 111 SHALL also fault.
REQ-023 paddr SHALL be the captured address with bits [1:0] forced to 0, held stable from SETUP through ACCESS.
REQ-024 Stores: SB pstrb=0001<<addr[1:0], pwdata=byte replicated x4; SH pstrb=0011<<addr[1:0], halfword replicated x2; SW pstrb=1111, pwdata=wdata.
REQ-025 Loads: pstrb=0000, pwrite=0; select lane by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-026 rdata SHALL be 0 whenever ready=0.
REQ-027 Inputs changing while not IDLE SHALL be ignored; only the captured values are used.
REQ-028 After ready, a held req SHALL start a new transfer from the IDLE cycle that follows; there are no back-to-back zero-gap transfers.

Reset
REQ-029 Reset SHALL force IDLE and set psel=0, penable=0, pwrite=0, pstrb=0, paddr=0, pwdata=0, ready=0, err=0, rdata=0.
REQ-030 Reset asserted mid-transfer SHALL abort it immediately with no ready pulse; a slave sees psel drop.

Structure
REQ-031 Package lsu_pkg SHALL hold the state enum, funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), and slave base/mask constants.
REQ-032 Sub-module lsu_lane_align SHALL be purely combinational and SHALL produce pstrb/pwdata and the extracted rdata; the FSM stays in apb_master_lsu.

Verification
REQ-033 SW 0xDEADBEEF to 0x1000_0004, pready=1 -> psel=0001, pstrb=1111, pwrite=1, ready asserted in cycle 3, err=0.
REQ-034 LB from 0x1000_0007 with prdata0=0x80FF_FFFF -> rdata=0xFFFF_FF80; LBU of the same access -> 0x0000_0080.
REQ-035 SH 0x1234 to 0x1000_1002 -> psel=0010, pstrb=1100, pwdata=0x1234_1234.
REQ-036 LW from 0x1000_3000 with pready low for 3 cycles -> penable held for 4 cycles, ready only in the final cycle, paddr stable throughout.
REQ-037 LW at 0x1000_0002 and LW at 0x2000_0000 -> no psel, ready=1 and err=1 in cycle 2, rdata=0.
REQ-038 Reset asserted in ACCESS -> all outputs 0 on the same edge, FSM in IDLE, no ready pulse.
